// File: rtl/pkt_frame_assembler.sv
// Packs a 32-byte payload plus little-endian FCS, runs one CRC check and hands the word downstream.
// Latency: crc_valid 1 cycle after the last FCS byte; pkt_valid 1 cycle after crc_done or CRC_TIMEOUT cycles in WAIT_CRC.
// Backpressure: in_ready low from START until the packet is accepted; pkt_valid holds while pkt_ready is low.
module pkt_frame_assembler #(
    parameter int CRC_TIMEOUT = 64,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_sof,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [255:0]         crc_data,
    output logic                 crc_valid,
    input  logic [31:0]          crc_result,
    input  logic                 crc_done,
    output logic [255:0]         pkt_data,
    output logic [31:0]          pkt_fcs,
    output logic                 pkt_crc_ok,
    output logic                 pkt_timeout,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ERR_CNT_W-1:0] abort_cnt
);
    typedef enum logic [2:0] {IDLE, COLLECT, FCS, START, WAIT_CRC, OUT} state_t;

    localparam int TW = $clog2(CRC_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(CRC_TIMEOUT - 1);

    state_t        state;
    logic [4:0]    byte_cnt;
    logic [1:0]    fcs_cnt;
    logic [31:0]   fcs;
    logic [TW-1:0] tmo_cnt;
    logic          acc;

    assign acc = in_valid && in_ready;

    // The collect/FCS registers are frozen from START until the packet leaves OUT,
    // so they double as the downstream payload without a second copy.
    assign pkt_data = crc_data;
    assign pkt_fcs  = fcs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            crc_valid   <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_crc_ok  <= 1'b0;
            pkt_timeout <= 1'b0;
            err_cnt     <= '0;
            abort_cnt   <= '0;
            crc_data    <= '0;
            fcs         <= '0;
            byte_cnt    <= '0;
            fcs_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            crc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (acc && in_sof) begin
                        crc_data[255 -: 8] <= in_data;
                        byte_cnt           <= 5'd1;
                        state              <= COLLECT;
                    end
                end
                COLLECT, FCS: begin
                    if (acc && in_sof) begin
                        // Early start of frame: restart with this byte as byte 0.
                        crc_data[255 -: 8] <= in_data;
                        byte_cnt           <= 5'd1;
                        state              <= COLLECT;
                        if (abort_cnt != '1)
                            abort_cnt <= abort_cnt + 1'b1;
                    end else if (acc && state == COLLECT) begin
                        crc_data[255 - 8*int'(byte_cnt) -: 8] <= in_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 5'd31) begin
                            state   <= FCS;
                            fcs_cnt <= 2'd0;
                        end
                    end else if (acc) begin
                        fcs[8*int'(fcs_cnt) +: 8] <= in_data;
                        fcs_cnt <= fcs_cnt + 1'b1;
                        if (fcs_cnt == 2'd3) begin
                            state     <= START;
                            in_ready  <= 1'b0;
                            crc_valid <= 1'b1;
                        end
                    end
                end
                START: begin
                    state   <= WAIT_CRC;
                    tmo_cnt <= '0;
                end
                WAIT_CRC: begin
                    if (crc_done) begin
                        pkt_crc_ok  <= (crc_result == fcs);
                        pkt_timeout <= 1'b0;
                        pkt_valid   <= 1'b1;
                        state       <= OUT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        pkt_crc_ok  <= 1'b0;
                        pkt_timeout <= 1'b1;
                        pkt_valid   <= 1'b1;
                        state       <= OUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (pkt_ready) begin
                        pkt_valid   <= 1'b0;
                        pkt_crc_ok  <= 1'b0;
                        pkt_timeout <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                        if (!pkt_crc_ok && err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_frame_assembler.sv
// Scoreboard bench for pkt_frame_assembler with a behavioural CRC-32 engine.
module tb_pkt_frame_assembler;
    localparam int CRC_TIMEOUT = 64;
    localparam int ERR_CNT_W   = 16;
    localparam int ENG_LAT     = 6;

    logic                 clk;
    logic                 rst;
    logic [7:0]           in_data;
    logic                 in_sof;
    logic                 in_valid;
    logic                 in_ready;
    logic [255:0]         crc_data;
    logic                 crc_valid;
    logic [31:0]          crc_result;
    logic                 crc_done;
    logic [255:0]         pkt_data;
    logic [31:0]          pkt_fcs;
    logic                 pkt_crc_ok;
    logic                 pkt_timeout;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ERR_CNT_W-1:0] abort_cnt;

    pkt_frame_assembler #(.CRC_TIMEOUT(CRC_TIMEOUT), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
        .crc_data(crc_data), .crc_valid(crc_valid), .crc_result(crc_result), .crc_done(crc_done),
        .pkt_data(pkt_data), .pkt_fcs(pkt_fcs), .pkt_crc_ok(pkt_crc_ok), .pkt_timeout(pkt_timeout),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .err_cnt(err_cnt), .abort_cnt(abort_cnt)
    );

    typedef struct {
        logic [255:0] data;
        logic [31:0]  fcs;
        logic         ok;
        logic         tmo;
    } exp_t;

    exp_t sbq[$];
    int   chk_count = 0;
    int   err_count = 0;
    int   err_exp   = 0;
    int   abort_exp = 0;
    int   cv_count  = 0;
    logic eng_stub  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reflected CRC-32 (poly 0xEDB88320, init and final xor all-ones), bytes 0..31 in order.
    function automatic logic [31:0] crc32(input logic [255:0] d);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < 32; k++) begin
            c = c ^ {24'h0, d[255 - 8*k -: 8]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // CRC engine: answers ENG_LAT cycles after the start pulse unless stubbed out.
    initial begin
        logic [255:0] d;
        crc_done   = 1'b0;
        crc_result = '0;
        forever begin
            @(negedge clk);
            if (crc_valid && !eng_stub) begin
                d = crc_data;
                repeat (ENG_LAT) @(negedge clk);
                crc_result = crc32(d);
                crc_done   = 1'b1;
                @(negedge clk);
                crc_done   = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (crc_valid) cv_count++;
        end
    end

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b, input logic sof);
        int guard;
        guard    = 0;
        in_data  = b;
        in_sof   = sof;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("in_ready_wait", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [255:0] p, input logic [31:0] f);
        for (int k = 0; k < 32; k++) send_byte(p[255 - 8*k -: 8], k == 0);
        for (int k = 0; k < 4; k++) send_byte(f[8*k +: 8], 1'b0);
    endtask

    task automatic recv(input int hold);
        exp_t e;
        logic [255:0] d0;
        if (hold > 0) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_data  = 8'h5A;
            d0 = pkt_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_pkt_valid", pkt_valid, 1);
                chk("bp_pkt_data", pkt_data, d0);
                chk("bp_in_ready", in_ready, 0);
            end
        end
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("pkt_data", pkt_data, e.data);
            chk("pkt_fcs", pkt_fcs, e.fcs);
            chk("pkt_crc_ok", pkt_crc_ok, e.ok);
            chk("pkt_timeout", pkt_timeout, e.tmo);
            if (!e.ok) err_exp++;
        end
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        chk("pkt_valid_drop", pkt_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("err_cnt", err_cnt, err_exp);
        chk("abort_cnt", abort_cnt, abort_exp);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [255:0] p, input logic [31:0] f, input int hold, input logic stub);
        exp_t e;
        int cv0, n;
        eng_stub = stub;
        e.data = p;
        e.fcs  = f;
        e.tmo  = stub;
        e.ok   = !stub && (crc32(p) == f);
        sbq.push_back(e);
        cv0 = cv_count;
        send_frame(p, f);
        chk("crc_valid_lat", crc_valid, 1);
        chk("crc_data", crc_data, p);
        chk("in_ready_start", in_ready, 0);
        n = 0;
        while (!pkt_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_latency", n, stub ? CRC_TIMEOUT + 1 : ENG_LAT + 1);
        chk("crc_valid_pulses", cv_count - cv0, 1);
        recv(hold);
        eng_stub = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [255:0] zeros, rp;
        zeros     = '0;
        rst       = 1'b1;
        in_data   = '0;
        in_sof    = 1'b0;
        in_valid  = 1'b0;
        pkt_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_crc_valid", crc_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_pkt_data", pkt_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset held 3 cycles in the middle of COLLECT.
        for (int k = 0; k < 6; k++) send_byte(8'hC0 + 8'(k), k == 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_in_ready", in_ready, 0);
            chk("mid_rst_pkt_valid", pkt_valid, 0);
            chk("mid_rst_crc_valid", crc_valid, 0);
        end
        chk("mid_rst_crc_data", crc_data, 0);
        chk("mid_rst_pkt_fcs", pkt_fcs, 0);
        chk("mid_rst_abort_cnt", abort_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(zeros, 32'h190A_55AD, 0, 1'b0);
        run_frame(zeros, 32'h180A_55AD, 0, 1'b0);

        // Early SOF at payload byte 10 of a first frame.
        for (int k = 0; k < 10; k++) send_byte(8'hEE, k == 0);
        abort_exp++;
        run_frame(zeros, 32'h190A_55AD, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            rp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_frame(rp, crc32(rp), (i == 1) ? 20 : 0, 1'b0);
        end

        rp = {8{32'hA5C3_0F96}};
        run_frame(rp, crc32(rp), 0, 1'b1);

        rp = {8{32'h1234_5678}};
        run_frame(rp, crc32(rp), 0, 1'b0);

        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end
endmodule
